data_mem_sized: RTL

//  Parametrised, byte-addressed, little-endian single-port data memory for the CPU load/store stage.

---
 rtl/data_mem_sized_if.sv | 24 ++
 rtl/data_mem_sized.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sized_if.sv
// rtl/data_mem_sized_if.sv - request/response bus of the sized data memory
interface data_mem_sized_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/data_mem_sized.sv
// rtl/data_mem_sized.sv - byte-addressed little-endian data memory with sized access and clear sweep
module data_mem_sized #(
    parameter int DEPTH_WORDS  = 128,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input logic             clk,
    input logic             rst,
    data_mem_sized_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   cnt_q;
    logic            run;
    logic            sweep_we;

    logic            accept;
    logic [AW-1:0]   req_idx;
    logic [1:0]      req_lane;
    logic            req_err;
    logic            st_en;
    logic            rd_en;
    logic [3:0]      st_be;
    logic [31:0]     st_data;

    logic            mem_we;
    logic [AW-1:0]   mem_idx;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            s1_valid;
    logic            s1_err;
    logic            s1_we;
    logic [1:0]      s1_size;
    logic            s1_unsigned;
    logic [1:0]      s1_lane;
    logic [31:0]     s1_word;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     ld_data;

    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [31:0]     rsp_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (!CLEAR_ON_RST || cnt_q == LAST_WORD) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        run      = 1'b0;
        sweep_we = 1'b0;
        case (state_q)
            ST_INIT: sweep_we = CLEAR_ON_RST;
            ST_RUN:  run      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (sweep_we) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.req_ready = run;
    assign bus.init_done = run;

    assign accept   = bus.req_valid && run;
    assign req_idx  = bus.req_addr[AW+1:2];
    assign req_lane = bus.req_addr[1:0];

    // Any address bit above the array span marks the access out of range.
    always_comb begin
        req_err = |bus.req_addr[31:AW+2];
        case (bus.req_size)
            2'b00:   ;
            2'b01:   if (req_lane[0]) req_err = 1'b1;
            2'b10:   if (req_lane != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        st_be   = 4'b1111;
        st_data = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                st_be   = 4'b0001 << req_lane;
                st_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = req_lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign st_en = accept && bus.req_we && !req_err;
    assign rd_en = accept && !bus.req_we && !req_err;

    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = req_idx;
        mem_be    = st_be;
        mem_wdata = st_data;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_idx   = cnt_q;
            mem_be    = 4'b1111;
            mem_wdata = '0;
        end else if (st_en) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            s1_word <= mem[req_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_err      <= 1'b0;
            s1_we       <= 1'b0;
            s1_size     <= 2'b00;
            s1_unsigned <= 1'b0;
            s1_lane     <= 2'b00;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err      <= req_err;
                s1_we       <= bus.req_we;
                s1_size     <= bus.req_size;
                s1_unsigned <= bus.req_unsigned;
                s1_lane     <= req_lane;
            end
        end
    end

    always_comb begin
        ld_data = '0;
        byte_v  = s1_word[{s1_lane, 3'b000} +: 8];
        half_v  = s1_lane[1] ? s1_word[31:16] : s1_word[15:0];
        if (!s1_err && !s1_we) begin
            case (s1_size)
                2'b00:   ld_data = {{24{!s1_unsigned && byte_v[7]}}, byte_v};
                2'b01:   ld_data = {{16{!s1_unsigned && half_v[15]}}, half_v};
                default: ld_data = s1_word;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= s1_valid;
            rsp_err_q   <= s1_valid && s1_err;
            rsp_rdata_q <= s1_valid ? ld_data : '0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule
